// File: rtl/pc_pkg.sv
// Shared definitions for the program counter and return-address stack.
package pc_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned RAS_DEPTH_DEF = 8;
  localparam int unsigned IBYTES_DEF    = 4;

  // Next-PC command encoding.
  typedef enum logic [2:0] {
    CmdSeq     = 3'b000,
    CmdHold    = 3'b001,
    CmdRel     = 3'b010,
    CmdAbs     = 3'b011,
    CmdCallRel = 3'b100,
    CmdCallAbs = 3'b101,
    CmdRet     = 3'b110,
    CmdRsvd    = 3'b111
  } pc_cmd_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty is refused. Clear wins over push/pop. Sticky ovf/unf flags
// are cleared only by reset.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clr,
  input  logic [XLEN-1:0] i_push_data,
  output logic [XLEN-1:0] o_top_data,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_ovf,
  output logic            o_unf
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  // r_top points at the next free slot; the top entry sits at r_top - 1.
  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PtrW-1:0] r_top;
  logic [PtrW-1:0] w_top_nxt;
  logic [PtrW-1:0] w_top_m1;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            r_ovf;
  logic            w_ovf_nxt;
  logic            r_unf;
  logic            w_unf_nxt;
  logic            w_wr_en;
  logic            w_empty;
  logic            w_full;

  assign w_top_m1   = r_top - PtrW'(1);
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CntW'(RAS_DEPTH));
  assign o_top_data = r_mem[w_top_m1];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;

  // Next pointer, count and sticky flags.
  always_comb begin
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
    w_wr_en   = 1'b0;
    if (i_clr) begin
      w_top_nxt = '0;
      w_cnt_nxt = '0;
    end else if (i_push) begin
      w_wr_en   = 1'b1;
      w_top_nxt = r_top + PtrW'(1);
      // When full, r_top already addresses the oldest entry.
      if (w_full) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CntW'(1);
      end
    end else if (i_pop) begin
      if (w_empty) begin
        w_unf_nxt = 1'b1;
      end else begin
        w_top_nxt = w_top_m1;
        w_cnt_nxt = r_cnt - CntW'(1);
      end
    end
  end

  // Pointer, count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_top <= w_top_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
    end
  end

  // Entry storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_wr_en) begin
      r_mem[r_top] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_ras.sv
// Fetch program counter with next-PC command decode and a return-address
// stack for call/return prediction. All outputs come straight from registers.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     IBYTES    = IBYTES_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_en,
  input  logic [2:0]      pc_cmd,
  input  logic [XLEN-1:0] pc_v,
  input  logic            ras_clr,
  output logic [XLEN-1:0] i_address,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam logic [XLEN-1:0] IncVal    = XLEN'(IBYTES);
  localparam logic [XLEN-1:0] AlignMask = XLEN'(IBYTES - 1);

  pc_cmd_e         w_cmd;
  logic [XLEN-1:0] r_pc;
  logic            r_mis;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_top_data;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;

  assign w_cmd = pc_cmd_e'(pc_cmd);
  assign w_seq = r_pc + IncVal;

  // Decode the command into the next PC and stack push/pop requests.
  // ras_clr suppresses push/pop; a RET under clear falls back to sequential.
  always_comb begin
    w_pc_nxt = r_pc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    if (if_en) begin
      unique case (w_cmd)
        CmdSeq, CmdRsvd: w_pc_nxt = w_seq;
        CmdHold:         w_pc_nxt = r_pc;
        CmdRel:          w_pc_nxt = r_pc + pc_v;
        CmdAbs:          w_pc_nxt = pc_v;
        CmdCallRel: begin
          w_push   = !ras_clr;
          w_pc_nxt = r_pc + pc_v;
        end
        CmdCallAbs: begin
          w_push   = !ras_clr;
          w_pc_nxt = pc_v;
        end
        CmdRet: begin
          w_pop    = !ras_clr;
          w_pc_nxt = (ras_clr || w_empty) ? w_seq : w_top_data;
        end
        default:         w_pc_nxt = w_seq;
      endcase
    end
  end

  // PC and misalignment flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc  <= RESET_PC;
      r_mis <= |(RESET_PC & AlignMask);
    end else begin
      r_pc  <= w_pc_nxt;
      r_mis <= |(w_pc_nxt & AlignMask);
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_clr       (ras_clr),
    .i_push_data (w_seq),
    .o_top_data  (w_top_data),
    .o_empty     (w_empty),
    .o_full      (ras_full),
    .o_ovf       (ras_ovf),
    .o_unf       (ras_unf)
  );

  assign i_address  = r_pc;
  assign misaligned = r_mis;
  assign ras_empty  = w_empty;

endmodule

// File: tb/tb_pc_ras.sv
// Self-checking bench for pc_ras: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_ras;

  localparam int unsigned     XLEN  = 32;
  localparam int unsigned     DEPTH = 8;
  localparam int unsigned     IB    = 4;
  localparam logic [31:0]     RPC   = 32'h0;

  localparam logic [2:0] SEQ = 3'd0, HOLD = 3'd1, REL = 3'd2, ABS = 3'd3;
  localparam logic [2:0] CREL = 3'd4, CABS = 3'd5, RET = 3'd6, RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_en = 1'b0;
  logic [2:0]  pc_cmd = 3'd0;
  logic [31:0] pc_v = 32'd0;
  logic        ras_clr = 1'b0;
  logic [31:0] i_address;
  logic        misaligned, ras_empty, ras_full, ras_ovf, ras_unf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: PC, return addresses (oldest at front), sticky flags.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RPC),
    .IBYTES    (IB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_en      (if_en),
    .pc_cmd     (pc_cmd),
    .pc_v       (pc_v),
    .ras_clr    (ras_clr),
    .i_address  (i_address),
    .misaligned (misaligned),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic rst, input logic en, input logic [2:0] cmd,
                              input logic [31:0] v, input logic clr);
    logic [31:0] seq;
    seq = m_pc + IB;
    if (!rst) begin
      m_pc = RPC;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (en) begin
        case (cmd)
          HOLD: m_pc = m_pc;
          REL:  m_pc = m_pc + v;
          ABS:  m_pc = v;
          CREL, CABS: begin
            if (!clr) begin
              if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
              end
              m_q.push_back(seq);
            end
            m_pc = (cmd == CREL) ? m_pc + v : v;
          end
          RET: begin
            if (clr) m_pc = seq;
            else if (m_q.size() == 0) begin
              m_unf = 1'b1;
              m_pc  = seq;
            end else m_pc = m_q.pop_back();
          end
          default: m_pc = seq;
        endcase
      end
      if (clr) m_q.delete();
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic en, input logic [2:0] cmd,
                      input logic [31:0] v, input logic clr);
    reset_n = rst;
    if_en   = en;
    pc_cmd  = cmd;
    pc_v    = v;
    ras_clr = clr;
    @(posedge clk);
    #1;
    model_update(rst, en, cmd, v, clr);
    reset_n = 1'b1;
    if_en   = 1'b0;
    ras_clr = 1'b0;
  endtask

  task automatic test_reset;
    // Reset must beat a simultaneous call with clear.
    step(1'b0, 1'b1, CABS, 32'h1234, 1'b1);
    n_checks++;
    if (i_address !== RPC) begin
      n_errors++; $display("FAIL reset_pc: got %h expected %h", i_address, RPC);
    end
    n_checks++;
    if ({ras_empty, ras_full, ras_ovf, ras_unf, misaligned} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_flags: got e=%b f=%b o=%b u=%b m=%b expected 1 0 0 0 0",
               ras_empty, ras_full, ras_ovf, ras_unf, misaligned);
    end
  endtask

  task automatic test_seq_hold;
    step(1'b0, 1'b0, SEQ, 32'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, SEQ, 32'd0, 1'b0);
      n_checks++;
      if (i_address !== 32'(4 * i)) begin
        n_errors++; $display("FAIL seq_%0d: got %h expected %h", i, i_address, 32'(4 * i));
      end
    end
    step(1'b1, 1'b0, SEQ, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'd12) begin
      n_errors++; $display("FAIL hold_en0: got %h expected %h", i_address, 32'd12);
    end
    step(1'b1, 1'b1, HOLD, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'd12) begin
      n_errors++; $display("FAIL hold_cmd: got %h expected %h", i_address, 32'd12);
    end
    step(1'b1, 1'b1, RSVD, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'd16) begin
      n_errors++; $display("FAIL rsvd_seq: got %h expected %h", i_address, 32'd16);
    end
  endtask

  task automatic test_rel_abs_wrap;
    step(1'b1, 1'b1, ABS, 32'h10, 1'b0);
    step(1'b1, 1'b1, REL, 32'hFFFF_FFF8, 1'b0);
    n_checks++;
    if (i_address !== 32'h8) begin
      n_errors++; $display("FAIL rel_neg: got %h expected %h", i_address, 32'h8);
    end
    step(1'b1, 1'b1, ABS, 32'hFFFF_FFFC, 1'b0);
    n_checks++;
    if (i_address !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL abs_top: got %h expected %h", i_address, 32'hFFFF_FFFC);
    end
    step(1'b1, 1'b1, SEQ, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'h0) begin
      n_errors++; $display("FAIL seq_wrap: got %h expected %h", i_address, 32'h0);
    end
  endtask

  task automatic test_call_ret;
    step(1'b1, 1'b1, ABS, 32'h20, 1'b0);
    step(1'b1, 1'b1, CABS, 32'h100, 1'b0);
    n_checks++;
    if (i_address !== 32'h100 || ras_empty !== 1'b0) begin
      n_errors++;
      $display("FAIL call_abs: got pc=%h empty=%b expected pc=%h empty=0",
               i_address, ras_empty, 32'h100);
    end
    step(1'b1, 1'b1, SEQ, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'h104) begin
      n_errors++; $display("FAIL call_seq: got %h expected %h", i_address, 32'h104);
    end
    step(1'b1, 1'b1, RET, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'h24 || ras_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL ret: got pc=%h empty=%b expected pc=%h empty=1",
               i_address, ras_empty, 32'h24);
    end
  endtask

  task automatic test_overflow_underflow;
    step(1'b0, 1'b0, SEQ, 32'd0, 1'b0);
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 1'b1, CREL, 32'd8, 1'b0);
    n_checks++;
    if (ras_full !== 1'b1 || ras_ovf !== 1'b1 || i_address !== 32'(8 * (DEPTH + 1))) begin
      n_errors++;
      $display("FAIL ovf: got full=%b ovf=%b pc=%h expected 1 1 %h",
               ras_full, ras_ovf, i_address, 32'(8 * (DEPTH + 1)));
    end
    // Call k at 8k pushed 8k+4; the oldest (k=0) was overwritten.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, RET, 32'd0, 1'b0);
      n_checks++;
      if (i_address !== 32'(8 * (DEPTH - i) + 4)) begin
        n_errors++;
        $display("FAIL lifo_%0d: got %h expected %h", i, i_address, 32'(8 * (DEPTH - i) + 4));
      end
    end
    step(1'b1, 1'b1, RET, 32'd0, 1'b0);
    n_checks++;
    if (ras_unf !== 1'b1 || i_address !== 32'd16 || ras_empty !== 1'b1 || ras_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL unf: got unf=%b pc=%h empty=%b ovf=%b expected 1 %h 1 1",
               ras_unf, i_address, ras_empty, ras_ovf, 32'd16);
    end
  endtask

  task automatic test_misaligned;
    step(1'b1, 1'b1, ABS, 32'h6, 1'b0);
    n_checks++;
    if (i_address !== 32'h6 || misaligned !== 1'b1) begin
      n_errors++; $display("FAIL mis_abs6: got pc=%h mis=%b expected 6 1", i_address, misaligned);
    end
    step(1'b1, 1'b1, SEQ, 32'd0, 1'b0);
    n_checks++;
    if (i_address !== 32'hA || misaligned !== 1'b1) begin
      n_errors++; $display("FAIL mis_seq: got pc=%h mis=%b expected a 1", i_address, misaligned);
    end
    step(1'b1, 1'b1, ABS, 32'h8, 1'b0);
    n_checks++;
    if (i_address !== 32'h8 || misaligned !== 1'b0) begin
      n_errors++; $display("FAIL mis_abs8: got pc=%h mis=%b expected 8 0", i_address, misaligned);
    end
  endtask

  task automatic test_clr_and_reset;
    step(1'b0, 1'b0, SEQ, 32'd0, 1'b0);
    step(1'b1, 1'b1, CABS, 32'h40, 1'b0);
    step(1'b1, 1'b1, CABS, 32'h200, 1'b1);
    n_checks++;
    if (ras_empty !== 1'b1 || i_address !== 32'h200) begin
      n_errors++;
      $display("FAIL call_clr: got empty=%b pc=%h expected 1 %h", ras_empty, i_address, 32'h200);
    end
    step(1'b1, 1'b1, CABS, 32'h300, 1'b0);
    step(1'b1, 1'b0, RET, 32'd0, 1'b1);
    n_checks++;
    if (ras_empty !== 1'b1 || i_address !== 32'h300) begin
      n_errors++;
      $display("FAIL clr_en0: got empty=%b pc=%h expected 1 %h", ras_empty, i_address, 32'h300);
    end
    step(1'b1, 1'b1, RET, 32'd0, 1'b1);
    n_checks++;
    if (ras_unf !== 1'b0 || i_address !== 32'h304) begin
      n_errors++;
      $display("FAIL ret_clr: got unf=%b pc=%h expected 0 %h", ras_unf, i_address, 32'h304);
    end
    step(1'b1, 1'b1, RET, 32'd0, 1'b0);
    step(1'b1, 1'b0, SEQ, 32'd0, 1'b1);
    n_checks++;
    if (ras_unf !== 1'b1 || i_address !== 32'h308) begin
      n_errors++;
      $display("FAIL unf_sticky: got unf=%b pc=%h expected 1 %h", ras_unf, i_address, 32'h308);
    end
    step(1'b0, 1'b1, CREL, 32'h10, 1'b0);
    n_checks++;
    if (i_address !== RPC ||
        {ras_empty, ras_full, ras_ovf, ras_unf, misaligned} !== 5'b10000) begin
      n_errors++;
      $display("FAIL mid_reset: got pc=%h e=%b f=%b o=%b u=%b m=%b expected %h 1 0 0 0 0",
               i_address, ras_empty, ras_full, ras_ovf, ras_unf, misaligned, RPC);
    end
  endtask

  task automatic test_random;
    logic        rst, en, clr;
    logic [2:0]  cmd;
    logic [31:0] v;
    step(1'b0, 1'b0, SEQ, 32'd0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      // Bias towards calls and returns so the stack fills and drains.
      cmd = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(4, 6)) : 3'($urandom_range(0, 7));
      v   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      step(rst, en, cmd, v, clr);
      n_checks++;
      if (i_address !== m_pc || misaligned !== (m_pc[1:0] != 2'b00) ||
          ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == DEPTH) ||
          ras_ovf !== m_ovf || ras_unf !== m_unf) begin
        n_errors++;
        $display("FAIL rand_%0d: got pc=%h m=%b e=%b f=%b o=%b u=%b expected %h %b %b %b %b %b",
                 i, i_address, misaligned, ras_empty, ras_full, ras_ovf, ras_unf,
                 m_pc, m_pc[1:0] != 2'b00, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_hold();
    test_rel_abs_wrap();
    test_call_ret();
    test_overflow_underflow();
    test_misaligned();
    test_clr_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
